sdio3w_responder: RTL and testbench

- Target (responder) end of the 3-wire serial bus (sclk, csn, bidirectional sdio).
- An external initiator clocks frames in on sclk. The block decodes a read/write header and address, then either commits write data to a host register port or drives read data back onto sdio through a tri-state enable.
- It runs on the system clock and oversamples sclk/csn/sdio. It sits between the pad-level sdio buffer and the block's register bank.

---
 rtl/sdio3w_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_sdio3w_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio3w_responder.sv
// -----------------------------------------------------------------------------
// sdio3w_responder
//   Responder end of a 3-wire serial register bus (sclk, csn, bidirectional
//   sdio). sclk/csn/sdio are oversampled on the system clock. A frame is one
//   R/W bit (1 = read), ADDR_W address bits, then DATA_W data bits, all MSB
//   first and sampled on sclk rise. Writes are committed to the register port.
//   Reads fetch reg_rdata and shift it out on sclk fall through a tri-state
//   enable.
//
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   sclk, csn        initiator serial clock / active-low frame select (async)
//   sdio_i           sdio pad input
//   sdio_o, sdio_oe  sdio pad output data / output enable (1 = drive)
//   reg_addr         register address, held from end of header to next frame
//   reg_wr           one-clk write strobe, reg_wdata valid alongside
//   reg_rd           one-clk read request
//   reg_rdata        read data, captured one clk after reg_rd
//   frame_err        one-clk pulse when a frame is aborted by csn rising early
// -----------------------------------------------------------------------------
module sdio3w_responder #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              csn,
    input  logic              sdio_i,
    output logic              sdio_o,
    output logic              sdio_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_err
);

    // One shift register serves the header, the write data and the read data.
    localparam int SH_W  = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int CNT_W = $clog2(SH_W + 1);

    typedef enum logic [2:0] {
        IDLE, HDR, WDATA, RTURN, RDATA, DONE
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, sdio_sync_q;
    logic                   sclk_prev_q, csn_prev_q;

    logic [SH_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic              rd_pend_q, rd_pend_d;
    logic              err_q, err_d;
    logic              oe_q, oe_d;
    logic              o_q, o_d;

    logic sclk_s, csn_s, sdio_s;
    logic sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic abort;
    logic [SH_W-1:0] shift_in;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];
    assign sdio_s = sdio_sync_q[SYNC_STAGES-1];

    assign sclk_rise =  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s &  sclk_prev_q;
    assign csn_rise  =  csn_s  & ~csn_prev_q;
    assign csn_fall  = ~csn_s  &  csn_prev_q;

    // sdio goes through the same number of stages as sclk, so the bit seen
    // alongside sclk_rise is the one present at the pin edge.
    assign shift_in = {shift_q[SH_W-2:0], sdio_s};

    // csn rising before the frame completes; it takes priority over any
    // sclk edge detected in the same clk.
    assign abort = csn_rise && (state_q inside {HDR, WDATA, RTURN, RDATA});

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        rd_pend_d = rd_q;
        err_d     = 1'b0;
        oe_d      = oe_q;
        o_d       = o_q;

        if (abort) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            o_d     = 1'b0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    oe_d = 1'b0;
                    o_d  = 1'b0;
                    if (csn_fall) begin
                        state_d = HDR;
                        cnt_d   = '0;
                    end
                end
                HDR: begin
                    if (sclk_rise) begin
                        shift_d = shift_in;
                        if (cnt_q == CNT_W'(ADDR_W)) begin
                            addr_d = shift_in[ADDR_W-1:0];
                            cnt_d  = '0;
                            if (shift_in[ADDR_W]) begin
                                rd_d    = 1'b1;
                                state_d = RTURN;
                            end else begin
                                state_d = WDATA;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        shift_d = shift_in;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            wr_d    = 1'b1;
                            wdata_d = shift_in[DATA_W-1:0];
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                RTURN: begin
                    // The sclk high phase guarantees the read data has been
                    // captured before the turnaround fall arrives.
                    if (sclk_fall) begin
                        oe_d    = 1'b1;
                        o_d     = shift_q[DATA_W-1];
                        shift_d = shift_q << 1;
                        cnt_d   = CNT_W'(1);
                        state_d = RDATA;
                    end else if (rd_pend_q) begin
                        shift_d = SH_W'(reg_rdata);
                    end
                end
                RDATA: begin
                    if (sclk_fall) begin
                        if (cnt_q == CNT_W'(DATA_W)) begin
                            oe_d    = 1'b0;
                            o_d     = 1'b0;
                            state_d = DONE;
                        end else begin
                            o_d     = shift_q[DATA_W-1];
                            shift_d = shift_q << 1;
                            cnt_d   = cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    oe_d = 1'b0;
                    if (csn_rise) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronizers restart at bus-idle levels so no false edge is
            // seen leaving reset.
            sclk_sync_q <= '0;
            csn_sync_q  <= '1;
            sdio_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b1;
            state_q     <= IDLE;
            // NOTE: the shift register and counter are reset too, so a frame
            // killed by reset leaves no stale bits behind.
            shift_q     <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            rd_pend_q   <= 1'b0;
            err_q       <= 1'b0;
            oe_q        <= 1'b0;
            o_q         <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn};
            sdio_sync_q <= {sdio_sync_q[SYNC_STAGES-2:0], sdio_i};
            sclk_prev_q <= sclk_s;
            csn_prev_q  <= csn_s;
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            rd_pend_q   <= rd_pend_d;
            err_q       <= err_d;
            oe_q        <= oe_d;
            o_q         <= o_d;
        end
    end

    assign sdio_o    = o_q;
    assign sdio_oe   = oe_q;
    assign reg_addr  = addr_q;
    assign reg_wr    = wr_q;
    assign reg_wdata = wdata_q;
    assign reg_rd    = rd_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_sdio3w_responder.sv
// -----------------------------------------------------------------------------
// tb_sdio3w_responder
//   Self-checking bench for sdio3w_responder. Acts as the bus initiator
//   (sclk/csn/sdio_i) and as the register bank (reg_rdata one clk after
//   reg_rd). Expected values come from the frame contents: a write must yield
//   exactly one strobe with the sent address/data, a read must return the
//   register value MSB first with sdio_oe high only across the data bits.
// -----------------------------------------------------------------------------
module tb_sdio3w_responder;

    localparam int ADDR_W      = 7;
    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FRAME_BITS  = 1 + ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk = 1'b0;
    logic              csn = 1'b1;
    logic              sdio_i = 1'b0;
    logic              sdio_o;
    logic              sdio_oe;
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_wr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_rd;
    logic [DATA_W-1:0] reg_rdata = 8'h5A;
    logic              frame_err;

    sdio3w_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .csn(csn), .sdio_i(sdio_i),
        .sdio_o(sdio_o), .sdio_oe(sdio_oe), .reg_addr(reg_addr),
        .reg_wr(reg_wr), .reg_wdata(reg_wdata), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Event monitor, cleared at the start of each step.
    int                wr_cnt, rd_cnt, err_cycles;
    logic              oe_seen;
    logic [ADDR_W-1:0] wr_addr_seen, rd_addr_seen;
    logic [DATA_W-1:0] wr_data_seen;

    // Register-bank value returned for the next read.
    logic [DATA_W-1:0] rdata_val;

    // Per-frame results from the initiator's point of view.
    logic [DATA_W-1:0]     rd_bits;
    logic [FRAME_BITS-1:0] oe_rise;
    int                    half;

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_wr) begin
                wr_cnt++;
                wr_addr_seen = reg_addr;
                wr_data_seen = reg_wdata;
            end
            if (reg_rd) begin
                rd_cnt++;
                rd_addr_seen = reg_addr;
            end
            if (frame_err) err_cycles++;
            if (sdio_oe) oe_seen = 1'b1;
        end
    end

    // Register bank: presents the value during the clk after reg_rd only,
    // garbage otherwise.
    always @(negedge clk) begin
        if (reg_rd) begin
            @(posedge clk);
            #1 reg_rdata = rdata_val;
            @(posedge clk);
            #1 reg_rdata = DATA_W'($urandom);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        wr_cnt = 0; rd_cnt = 0; err_cycles = 0; oe_seen = 1'b0;
        wr_addr_seen = '0; rd_addr_seen = '0; wr_data_seen = '0;
    endtask

    // One sclk period: low phase, rise (initiator samples sdio_o), high, fall.
    task automatic bit_cycle(input logic drive, input logic d, output logic s, output logic oe);
        sdio_i = drive ? d : 1'($urandom);
        wait_clks(half);
        s  = sdio_o;
        oe = sdio_oe;
        sclk = 1'b1;
        wait_clks(half);
        sclk = 1'b0;
    endtask

    // Drop csn and clock the header, data_bits data bits and some extra
    // pulses. csn is left low; end_frame() closes it.
    task automatic frame(input logic rw, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input int data_bits,
                         input int extra);
        logic [ADDR_W:0] hdr;
        logic s, oe;
        half    = $urandom_range(5, 9);
        hdr     = {rw, addr};
        rd_bits = '0;
        oe_rise = '0;
        csn = 1'b0;
        wait_clks(half);
        for (int i = ADDR_W; i >= 0; i--) begin
            bit_cycle(1'b1, hdr[i], s, oe);
            oe_rise = {oe_rise[FRAME_BITS-2:0], oe};
        end
        for (int i = 0; i < data_bits; i++) begin
            bit_cycle(!rw, wdata[DATA_W-1-i], s, oe);
            rd_bits[DATA_W-1-i] = s;
            oe_rise = {oe_rise[FRAME_BITS-2:0], oe};
        end
        for (int i = 0; i < extra; i++) bit_cycle(1'b1, 1'($urandom), s, oe);
    endtask

    task automatic end_frame();
        wait_clks(half);
        csn = 1'b1;
        wait_clks(12);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " sdio_o"},    32'(sdio_o),    32'h0);
        check({tag, " sdio_oe"},   32'(sdio_oe),   32'h0);
        check({tag, " reg_addr"},  32'(reg_addr),  32'h0);
        check({tag, " reg_wr"},    32'(reg_wr),    32'h0);
        check({tag, " reg_wdata"}, 32'(reg_wdata), 32'h0);
        check({tag, " reg_rd"},    32'(reg_rd),    32'h0);
        check({tag, " frame_err"}, 32'(frame_err), 32'h0);
    endtask

    initial begin
        logic              rw;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;

        clear_mon();
        rdata_val = '0;
        half = 6;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(4);
        check_outputs_zero("reset");

        // Write 0x15 <= 0xA5.
        clear_mon();
        frame(1'b0, 7'h15, 8'hA5, DATA_W, 0);
        end_frame();
        check("wr1 count", 32'(wr_cnt), 32'd1);
        check("wr1 addr", 32'(wr_addr_seen), 32'h15);
        check("wr1 data", 32'(wr_data_seen), 32'hA5);
        check("wr1 oe", 32'(oe_seen), 32'h0);
        check("wr1 err", 32'(err_cycles), 32'd0);
        check("wr1 rd", 32'(rd_cnt), 32'd0);

        // Read 0x2A -> 0x3C.
        clear_mon();
        rdata_val = 8'h3C;
        frame(1'b1, 7'h2A, '0, DATA_W, 0);
        wait_clks(6);
        check("rd1 oe after 9th fall", 32'(sdio_oe), 32'h0);
        end_frame();
        check("rd1 count", 32'(rd_cnt), 32'd1);
        check("rd1 addr", 32'(rd_addr_seen), 32'h2A);
        check("rd1 bits", 32'(rd_bits), 32'h3C);
        check("rd1 oe at rises", 32'(oe_rise), 32'h00FF);
        check("rd1 wr", 32'(wr_cnt), 32'd0);
        check("rd1 err", 32'(err_cycles), 32'd0);

        // Abort a write after 4 data bits, then a full write.
        clear_mon();
        frame(1'b0, 7'h33, 8'h5A, 4, 0);
        end_frame();
        check("abort_wr wr", 32'(wr_cnt), 32'd0);
        check("abort_wr err", 32'(err_cycles), 32'd1);
        clear_mon();
        frame(1'b0, 7'h01, 8'hFF, DATA_W, 0);
        end_frame();
        check("post_abort count", 32'(wr_cnt), 32'd1);
        check("post_abort addr", 32'(wr_addr_seen), 32'h01);
        check("post_abort data", 32'(wr_data_seen), 32'hFF);
        check("post_abort err", 32'(err_cycles), 32'd0);

        // Abort a read after 3 data bits; oe must drop within SYNC_STAGES+1 clk.
        clear_mon();
        rdata_val = 8'hC7;
        frame(1'b1, 7'h05, '0, 3, 0);
        check("abort_rd oe before", 32'(sdio_oe), 32'h1);
        check("abort_rd bits", 32'(rd_bits[DATA_W-1 -: 3]), 32'h6);
        csn = 1'b1;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1;
        check("abort_rd oe after", 32'(sdio_oe), 32'h0);
        wait_clks(12);
        check("abort_rd err", 32'(err_cycles), 32'd1);
        check("abort_rd wr", 32'(wr_cnt), 32'd0);

        // Extra sclk pulses after a complete write.
        clear_mon();
        frame(1'b0, 7'h4C, 8'h96, DATA_W, 5);
        end_frame();
        check("extra count", 32'(wr_cnt), 32'd1);
        check("extra data", 32'(wr_data_seen), 32'h96);
        check("extra oe", 32'(oe_seen), 32'h0);
        check("extra err", 32'(err_cycles), 32'd0);

        // Reset during read data bit 2, initiator releases the bus at once.
        clear_mon();
        rdata_val = 8'hE1;
        frame(1'b1, 7'h22, '0, 2, 0);
        check("rst_rd oe before", 32'(sdio_oe), 32'h1);
        rst = 1'b1;
        csn = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("rst_rd");
        rst = 1'b0;
        wait_clks(12);
        check("rst_rd err", 32'(err_cycles), 32'd0);
        check("rst_rd wr", 32'(wr_cnt), 32'd0);
        clear_mon();
        rdata_val = 8'h81;
        frame(1'b1, 7'h10, '0, DATA_W, 0);
        end_frame();
        check("post_rst count", 32'(rd_cnt), 32'd1);
        check("post_rst addr", 32'(rd_addr_seen), 32'h10);
        check("post_rst bits", 32'(rd_bits), 32'h81);
        check("post_rst err", 32'(err_cycles), 32'd0);

        // Randomized complete frames.
        for (int n = 0; n < 24; n++) begin
            rw = 1'($urandom);
            a  = ADDR_W'($urandom);
            d  = DATA_W'($urandom);
            clear_mon();
            rdata_val = d;
            frame(rw, a, d, DATA_W, 0);
            end_frame();
            check("rnd err", 32'(err_cycles), 32'd0);
            if (rw) begin
                check("rnd rd count", 32'(rd_cnt), 32'd1);
                check("rnd rd addr", 32'(rd_addr_seen), 32'(a));
                check("rnd rd bits", 32'(rd_bits), 32'(d));
                check("rnd rd wr", 32'(wr_cnt), 32'd0);
            end else begin
                check("rnd wr count", 32'(wr_cnt), 32'd1);
                check("rnd wr addr", 32'(wr_addr_seen), 32'(a));
                check("rnd wr data", 32'(wr_data_seen), 32'(d));
                check("rnd wr oe", 32'(oe_seen), 32'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
